matrix_tile_sequencer: RTL and testbench

MATRIX_TILE_SEQUENCER -- requirements
Module: matrix_tile_sequencer

---
 rtl/matrix_tile_sequencer.sv | 144 ++++++++++++++
 tb/tb_matrix_tile_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/matrix_tile_sequencer.sv
// ============================================================================
// Module  : matrix_tile_sequencer
// Brief   : Walks layer/row/col positions of a tiled matrix store, row- or
//           element-granular, with optional wrap to origin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_tile_sequencer #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int LAYERS = 4,
    parameter int IDX_W  = 32,
    parameter int WRAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             step_valid,
    output logic             step_ready,
    output logic [IDX_W-1:0] layer_index,
    output logic [IDX_W-1:0] row_index,
    output logic [IDX_W-1:0] col_index,
    output logic [IDX_W-1:0] linear_addr,
    output logic             last_row,
    output logic             last_layer,
    output logic             busy,
    output logic             done,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_ROW_LAST   = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] c_COL_LAST   = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] c_LAYER_LAST = IDX_W'(LAYERS - 1);
    localparam logic [IDX_W-1:0] c_COLS       = IDX_W'(COLS);

    state_t           r_state, w_state;
    logic             r_mode, w_mode;
    logic [IDX_W-1:0] r_layer, w_layer;
    logic [IDX_W-1:0] r_row, w_row;
    logic [IDX_W-1:0] r_col, w_col;
    logic [IDX_W-1:0] r_addr, w_addr;
    logic             r_wrap, w_wrap;
    logic             r_busy, r_done, r_last_row, r_last_layer;

    logic w_row_end, w_col_end, w_layer_end, w_at_last;

    assign w_row_end   = (r_row == c_ROW_LAST);
    assign w_col_end   = (r_col == c_COL_LAST);
    assign w_layer_end = (r_layer == c_LAYER_LAST);
    // In row mode the column stays 0, so the column does not gate the end.
    assign w_at_last   = w_layer_end && w_row_end && (!r_mode || w_col_end);

    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_layer = r_layer;
        w_row   = r_row;
        w_col   = r_col;
        w_addr  = r_addr;
        w_wrap  = 1'b0;
        if (start) begin
            w_state = ST_RUN;
            w_mode  = mode;
            w_layer = '0;
            w_row   = '0;
            w_col   = '0;
            w_addr  = '0;
        end else if ((r_state == ST_RUN) && step_valid) begin
            if (w_at_last) begin
                if (WRAP != 0) begin
                    w_layer = '0;
                    w_row   = '0;
                    w_col   = '0;
                    w_addr  = '0;
                    w_wrap  = 1'b1;
                end else begin
                    w_state = ST_DONE;
                end
            end else if (r_mode && !w_col_end) begin
                w_col  = r_col + 1'b1;
                w_addr = r_addr + 1'b1;
            end else begin
                w_col  = '0;
                w_addr = r_mode ? (r_addr + 1'b1) : (r_addr + c_COLS);
                if (w_row_end) begin
                    w_row   = '0;
                    w_layer = r_layer + 1'b1;
                end else begin
                    w_row = r_row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mode       <= 1'b0;
            r_layer      <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_addr       <= '0;
            r_wrap       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_last_row   <= (ROWS == 1);
            r_last_layer <= (LAYERS == 1);
        end else begin
            r_state      <= w_state;
            r_mode       <= w_mode;
            r_layer      <= w_layer;
            r_row        <= w_row;
            r_col        <= w_col;
            r_addr       <= w_addr;
            r_wrap       <= w_wrap;
            r_busy       <= (w_state == ST_RUN);
            r_done       <= (w_state == ST_DONE);
            r_last_row   <= (w_row == c_ROW_LAST);
            r_last_layer <= (w_layer == c_LAYER_LAST);
        end
    end

    assign step_ready  = r_busy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign wrap_pulse  = r_wrap;
    assign layer_index = r_layer;
    assign row_index   = r_row;
    assign col_index   = r_col;
    assign linear_addr = r_addr;
    assign last_row    = r_last_row;
    assign last_layer  = r_last_layer;

endmodule

`default_nettype wire

// File: tb/tb_matrix_tile_sequencer.sv
// ============================================================================
// Module  : tb_matrix_tile_sequencer
// Brief   : Drives three sequencer geometries with shared stimulus and checks
//           them against a position-counter reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, mode, step_valid;

    logic [2:0][31:0] li, ri, ci, la;
    logic [2:0]       srdy, lrow, llay, bsy, dn, wp;

    matrix_tile_sequencer #(.ROWS(3), .COLS(2), .LAYERS(2), .IDX_W(32), .WRAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .step_valid(step_valid),
        .step_ready(srdy[0]), .layer_index(li[0]), .row_index(ri[0]), .col_index(ci[0]),
        .linear_addr(la[0]), .last_row(lrow[0]), .last_layer(llay[0]),
        .busy(bsy[0]), .done(dn[0]), .wrap_pulse(wp[0]));

    matrix_tile_sequencer #(.ROWS(3), .COLS(2), .LAYERS(2), .IDX_W(32), .WRAP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .step_valid(step_valid),
        .step_ready(srdy[1]), .layer_index(li[1]), .row_index(ri[1]), .col_index(ci[1]),
        .linear_addr(la[1]), .last_row(lrow[1]), .last_layer(llay[1]),
        .busy(bsy[1]), .done(dn[1]), .wrap_pulse(wp[1]));

    matrix_tile_sequencer #(.ROWS(1), .COLS(1), .LAYERS(1), .IDX_W(32), .WRAP(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .step_valid(step_valid),
        .step_ready(srdy[2]), .layer_index(li[2]), .row_index(ri[2]), .col_index(ci[2]),
        .linear_addr(la[2]), .last_row(lrow[2]), .last_layer(llay[2]),
        .busy(bsy[2]), .done(dn[2]), .wrap_pulse(wp[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int g_rows(int k);   return (k == 2) ? 1 : 3; endfunction
    function automatic int g_cols(int k);   return (k == 2) ? 1 : 2; endfunction
    function automatic int g_layers(int k); return (k == 2) ? 1 : 2; endfunction
    function automatic bit g_wrap(int k);   return (k == 1); endfunction

    // Model: 0=idle 1=run 2=done; m_p counts positions stepped since start.
    int m_st[3];
    int m_p[3];
    bit m_mode[3];
    bit m_wrap[3];

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int total;
            total = g_layers(k) * g_rows(k) * (m_mode[k] ? g_cols(k) : 1);
            m_wrap[k] = 1'b0;
            if (reset) begin
                m_st[k] = 0; m_p[k] = 0; m_mode[k] = 1'b0;
            end else if (start) begin
                m_st[k] = 1; m_p[k] = 0; m_mode[k] = mode;
            end else if (m_st[k] == 1 && step_valid) begin
                if (m_p[k] == total - 1) begin
                    if (g_wrap(k)) begin m_p[k] = 0; m_wrap[k] = 1'b1; end
                    else m_st[k] = 2;
                end else begin
                    m_p[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int r, c, lay, row, col, addr;
            r = g_rows(k); c = g_cols(k);
            if (m_mode[k]) begin
                lay = m_p[k] / (r * c); row = (m_p[k] / c) % r; col = m_p[k] % c; addr = m_p[k];
            end else begin
                lay = m_p[k] / r; row = m_p[k] % r; col = 0; addr = m_p[k] * c;
            end
            check($sformatf("d%0d_layer", k), 64'(li[k]), 64'(lay));
            check($sformatf("d%0d_row", k), 64'(ri[k]), 64'(row));
            check($sformatf("d%0d_col", k), 64'(ci[k]), 64'(col));
            check($sformatf("d%0d_addr", k), 64'(la[k]), 64'(addr));
            check($sformatf("d%0d_last_row", k), 64'(lrow[k]), 64'(row == r - 1));
            check($sformatf("d%0d_last_layer", k), 64'(llay[k]), 64'(lay == g_layers(k) - 1));
            check($sformatf("d%0d_ready", k), 64'(srdy[k]), 64'(m_st[k] == 1));
            check($sformatf("d%0d_busy", k), 64'(bsy[k]), 64'(m_st[k] == 1));
            check($sformatf("d%0d_done", k), 64'(dn[k]), 64'(m_st[k] == 2));
            check($sformatf("d%0d_wrap", k), 64'(wp[k]), 64'(m_wrap[k]));
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit m, input bit v);
        reset = r; start = s; mode = m; step_valid = v;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; step_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_p[k] = 0; m_mode[k] = 1'b0; m_wrap[k] = 1'b0;
        end
        @(posedge clk);
        cyc(1, 0, 0, 0);
        // Row mode through to DONE, then steps in DONE are ignored.
        cyc(0, 1, 0, 0);
        repeat (6) cyc(0, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 1);
        // Element mode, full pass incl. wrap on the WRAP=1 instance.
        cyc(0, 1, 1, 0);
        repeat (13) cyc(0, 0, 0, 1);
        // Start collides with a step mid-run at addr5.
        cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        // Reset mid-run, step_valid ignored in IDLE.
        repeat (4) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 1, 1);
        // All-ones geometry: single step reaches DONE.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (2000) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
